// File: rtl/prescalar_bank.sv
// prescalar_bank
//   Multi-channel programmable clock divider. Each channel produces a 50%-duty
//   divided clock with a runtime half-period and a one-cycle tick on every
//   rising edge. A channel can free-run, single-step one full period while
//   stopped, and be phase-aligned with the other running channels by a common
//   sync pulse.
//
// Ports
//   clock_in     in   system clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   half_period  in   per-channel half-period H; ch k = [k*CNT_W +: CNT_W]
//   run          in   per-channel level; 1 = free-run
//   step         in   per-channel pulse; one output period while stopped
//   sync         in   pulse; restart the high phase of all running channels
//   clock_out    out  divided clocks, straight from flops
//   tick         out  one-cycle strobe on each rising edge of clock_out[k]
//   busy         out  1 while the channel is not stopped
//
// Per-channel FSM
//   state      | meaning
//   -----------+------------------------------------------------------------
//   ST_STOP    | idle, clock_out low, counter held at 0
//   ST_RUN     | free-running, toggles every E cycles
//   ST_STEP_HI | single step, high half of the one output period
//   ST_STEP_LO | single step, low half, then back to ST_STOP
module prescalar_bank #(
  parameter int NUM_CH = 3,
  parameter int CNT_W  = 25
) (
  input  logic                    clock_in,
  input  logic                    reset_n,
  input  logic [NUM_CH*CNT_W-1:0] half_period,
  input  logic [NUM_CH-1:0]       run,
  input  logic [NUM_CH-1:0]       step,
  input  logic                    sync,
  output logic [NUM_CH-1:0]       clock_out,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       busy
);

  typedef enum logic [1:0] {
    ST_STOP    = 2'd0,
    ST_RUN     = 2'd1,
    ST_STEP_HI = 2'd2,
    ST_STEP_LO = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  for (genvar g_ch = 0; g_ch < NUM_CH; g_ch++) begin : g_chan
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_shadow;
    logic             r_out;
    logic             r_tick;
    logic             r_busy;

    logic [CNT_W-1:0] w_hp;
    logic [CNT_W-1:0] w_last_cnt;
    logic             w_last;

    assign w_hp = half_period[g_ch*CNT_W +: CNT_W];
    // A zero half-period behaves as one: the last count of a phase is E-1.
    assign w_last_cnt = (r_shadow == '0) ? '0 : (r_shadow - CNT_ONE);
    assign w_last     = (r_cnt == w_last_cnt);

    always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
        r_state  <= ST_STOP;
        r_cnt    <= '0;
        r_shadow <= '0;
        r_out    <= 1'b0;
        r_tick   <= 1'b0;
        r_busy   <= 1'b0;
      end else begin
        r_tick <= 1'b0;
        case (r_state)
          ST_STOP: begin
            r_cnt <= '0;
            r_out <= 1'b0;
            // run outranks step when both arrive together
            if (run[g_ch] || step[g_ch]) begin
              r_state  <= run[g_ch] ? ST_RUN : ST_STEP_HI;
              r_out    <= 1'b1;
              r_tick   <= 1'b1;
              r_shadow <= w_hp;
              r_busy   <= 1'b1;
            end
          end

          ST_RUN: begin
            if (sync && run[g_ch]) begin
              // sync outranks a toggle due in the same cycle
              r_cnt    <= '0;
              r_out    <= 1'b1;
              r_tick   <= 1'b1;
              r_shadow <= w_hp;
            end else if (!run[g_ch] && !r_out) begin
              // a low phase may be cut short; a high phase never is
              r_state <= ST_STOP;
              r_cnt   <= '0;
              r_busy  <= 1'b0;
            end else if (w_last) begin
              r_cnt    <= '0;
              r_shadow <= w_hp;
              if (r_out) begin
                r_out <= 1'b0;
                if (!run[g_ch]) begin
                  r_state <= ST_STOP;
                  r_busy  <= 1'b0;
                end
              end else begin
                r_out  <= 1'b1;
                r_tick <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
            end
          end

          ST_STEP_HI: begin
            if (w_last) begin
              r_state  <= ST_STEP_LO;
              r_cnt    <= '0;
              r_out    <= 1'b0;
              r_shadow <= w_hp;
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
            end
          end

          ST_STEP_LO: begin
            if (w_last) begin
              r_state <= ST_STOP;
              r_cnt   <= '0;
              r_busy  <= 1'b0;
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
            end
          end

          default: begin
            r_state <= ST_STOP;
            r_cnt   <= '0;
            r_out   <= 1'b0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end

    assign clock_out[g_ch] = r_out;
    assign tick[g_ch]      = r_tick;
    assign busy[g_ch]      = r_busy;
  end

endmodule
